// File: rtl/g10_rx_block_sync.sv
// g10_rx_block_sync: 64b/66b bit-slip block synchronizer with lock FSM; G10_RX_SYNC_STATS_EN adds err_cnt/lock_loss_cnt
module g10_rx_block_sync #(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int ERR_LIMIT = 16
) (
    input  logic        clk_ref,
    input  logic        rst_ref,
    input  logic [31:0] pma_data,
    input  logic        pma_valid,
    output logic [63:0] blk_data,
    output logic [1:0]  blk_hdr,
    output logic        blk_valid,
`ifdef G10_RX_SYNC_STATS_EN
    output logic [15:0] err_cnt,
    output logic [15:0] lock_loss_cnt,
`endif
    output logic        block_lock
);
    localparam logic       HUNT   = 1'b0;
    localparam logic       LOCKED = 1'b1;
    localparam logic [6:0] LOCK_N = 7'(LOCK_CNT);
    localparam logic [6:0] WIN_N  = 7'(WINDOW);
    localparam logic [4:0] ERR_N  = 5'(ERR_LIMIT);

    logic        state, slip;
    logic [97:0] sr, sr_app, sr_nxt;
    logic [6:0]  fill, nf, fill_nxt;
    logic [6:0]  sh_cnt, blk_cnt, sh_inc, blk_inc;
    logic [4:0]  invld_cnt, inv_inc;
    logic        take, drop, sh_ok, lock_hit, loss, win_end, emit;

    // bits above fill are always zero, so new words can simply be OR-ed in
    always_comb begin
        nf       = fill + (pma_valid ? 7'd32 : 7'd0);
        sr_app   = pma_valid ? sr | ({66'd0, pma_data} << fill) : sr;
        take     = !slip && nf >= 7'd66;
        drop     = slip && nf >= 7'd67;
        sr_nxt   = take ? sr_app >> 66 : drop ? sr_app >> 67 : sr_app;
        fill_nxt = take ? nf - 7'd66 : drop ? nf - 7'd67 : nf;
        sh_ok    = ^sr_app[1:0];
        sh_inc   = sh_cnt + 7'd1;
        blk_inc  = blk_cnt + 7'd1;
        inv_inc  = invld_cnt + {4'd0, !sh_ok};
        emit     = take && state == LOCKED;
        lock_hit = take && state == HUNT && sh_ok && sh_inc == LOCK_N;
        loss     = emit && inv_inc == ERR_N;
        win_end  = emit && blk_inc == WIN_N;
    end

    always_ff @(posedge clk_ref) begin
        if (rst_ref) begin
            sr        <= '0;
            fill      <= '0;
            slip      <= 1'b0;
            state     <= HUNT;
            sh_cnt    <= '0;
            blk_cnt   <= '0;
            invld_cnt <= '0;
            blk_valid <= 1'b0;
            blk_data  <= '0;
            blk_hdr   <= '0;
        end else begin
            sr        <= sr_nxt;
            fill      <= fill_nxt;
            slip      <= take ? (state == HUNT && !sh_ok) || loss : slip && !drop;
            blk_valid <= emit;
            if (emit)
                {blk_data, blk_hdr} <= sr_app[65:0];
            if (take && state == HUNT) begin
                sh_cnt <= sh_ok && !lock_hit ? sh_inc : 7'd0;
                state  <= lock_hit ? LOCKED : HUNT;
            end
            if (emit) begin
                blk_cnt   <= loss || win_end ? 7'd0 : blk_inc;
                invld_cnt <= loss || win_end ? 5'd0 : inv_inc;
                state     <= loss ? HUNT : LOCKED;
            end
        end
    end

    assign block_lock = state == LOCKED;

`ifdef G10_RX_SYNC_STATS_EN
    always_ff @(posedge clk_ref) begin
        if (rst_ref) begin
            err_cnt       <= '0;
            lock_loss_cnt <= '0;
        end else begin
            if (emit && !sh_ok && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            if (loss && lock_loss_cnt != 16'hFFFF)
                lock_loss_cnt <= lock_loss_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_g10_rx_block_sync.sv
// tb_g10_rx_block_sync: randomized stimulus against a bit-queue reference model of the block synchronizer
module tb_g10_rx_block_sync;
    localparam int LOCK_CNT  = 64;
    localparam int WINDOW    = 64;
    localparam int ERR_LIMIT = 16;

    logic        clk_ref = 0;
    logic        rst_ref;
    logic [31:0] pma_data;
    logic        pma_valid;
    logic [63:0] blk_data;
    logic [1:0]  blk_hdr;
    logic        blk_valid;
    logic        block_lock;
`ifdef G10_RX_SYNC_STATS_EN
    logic [15:0] err_cnt;
    logic [15:0] lock_loss_cnt;
`endif

    g10_rx_block_sync #(.LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk_ref(clk_ref),
        .rst_ref(rst_ref),
        .pma_data(pma_data),
        .pma_valid(pma_valid),
        .blk_data(blk_data),
        .blk_hdr(blk_hdr),
        .blk_valid(blk_valid),
`ifdef G10_RX_SYNC_STATS_EN
        .err_cnt(err_cnt),
        .lock_loss_cnt(lock_loss_cnt),
`endif
        .block_lock(block_lock)
    );

    always #5 clk_ref = ~clk_ref;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    // transmit side: wire bit stream and the blocks it was built from ({data,hdr}, bit 0 first)
    bit          tx[$];
    logic [65:0] sd[$];
    logic [65:0] outq[$];

    // reference model state
    bit          mq[$];
    bit          m_slip, m_lock, ev, ok;
    int          m_sh, m_blk, m_inv, m_err, m_loss, wcnt, m_slips, slips_at_lock;
    logic [65:0] eo, cand;

    // observations
    bit          prev_lock = 0;
    int          lock_words = 0, fall_n = -1, fall_err = -1, fall_loss = -1;
    logic [65:0] fall_d;

    task automatic chk(input string nm, input logic [65:0] a, input logic [65:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [65:0] oq(input int i);
        return i < outq.size() ? outq[i] : 'x;
    endfunction

    always @(posedge clk_ref) begin
        if (rst_ref) begin
            mq.delete();
            m_slip = 0; m_lock = 0; m_sh = 0; m_blk = 0; m_inv = 0;
            m_err = 0; m_loss = 0; wcnt = 0; m_slips = 0; slips_at_lock = -1;
            ev = 0; eo = '0;
        end else begin
            ev = 0;
            if (pma_valid) begin
                wcnt++;
                for (int i = 0; i < 32; i++) mq.push_back(pma_data[i]);
            end
            if (m_slip) begin
                if (mq.size() >= 67) begin
                    for (int i = 0; i < 67; i++) void'(mq.pop_front());
                    m_slip = 0;
                    m_slips++;
                end
            end else if (mq.size() >= 66) begin
                for (int i = 0; i < 66; i++) cand[i] = mq.pop_front();
                ok = cand[1:0] == 2'b01 || cand[1:0] == 2'b10;
                if (m_lock) begin
                    ev = 1; eo = cand; m_blk++;
                    if (!ok) begin
                        m_inv++;
                        if (m_err < 65535) m_err++;
                    end
                    if (m_inv == ERR_LIMIT) begin
                        m_lock = 0; m_slip = 1; m_blk = 0; m_inv = 0;
                        if (m_loss < 65535) m_loss++;
                    end else if (m_blk == WINDOW) begin
                        m_blk = 0; m_inv = 0;
                    end
                end else if (ok) begin
                    m_sh++;
                    if (m_sh == LOCK_CNT) begin
                        m_lock = 1; m_sh = 0;
                        if (slips_at_lock < 0) slips_at_lock = m_slips;
                    end
                end else begin
                    m_sh = 0; m_slip = 1;
                end
            end
        end
    end

    always @(negedge clk_ref) begin
        if (chk_en) begin
            chk("blk_valid", 66'(blk_valid), 66'(ev));
            chk("block_lock", 66'(block_lock), 66'(m_lock));
            if (ev) chk("blk_out", {blk_data, blk_hdr}, eo);
`ifdef G10_RX_SYNC_STATS_EN
            chk("err_cnt", 66'(err_cnt), 66'(m_err));
            chk("lock_loss_cnt", 66'(lock_loss_cnt), 66'(m_loss));
`endif
            if (blk_valid) outq.push_back({blk_data, blk_hdr});
            if (block_lock && !prev_lock && lock_words == 0) lock_words = wcnt;
            if (!block_lock && prev_lock && blk_valid && fall_n < 0) begin
                fall_n = outq.size();
                fall_d = {blk_data, blk_hdr};
`ifdef G10_RX_SYNC_STATS_EN
                fall_err  = int'(err_cnt);
                fall_loss = int'(lock_loss_cnt);
`endif
            end
            prev_lock = block_lock;
        end
    end

    task automatic add_blocks(input int n, input int bad_pct);
        logic [65:0] b;
        bit bad;
        for (int k = 0; k < n; k++) begin
            bad = $urandom_range(0, 99) < bad_pct;
            b[65:2] = {$urandom, $urandom};
            b[1:0] = bad ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
            sd.push_back(b);
            for (int i = 0; i < 66; i++) tx.push_back(b[i]);
        end
    endtask

    task automatic add_junk(input int n);
        for (int i = 0; i < n; i++) tx.push_back(1'($urandom));
    endtask

    // mode 0: continuous, 1: alternating 1-0-1-0, 2: random gaps
    task automatic feed(input int n, input int mode);
        int sent = 0, cyc = 0;
        bit v;
        logic [31:0] w;
        while (sent < n && cyc < 4 * n + 8) begin
            @(posedge clk_ref); #1;
            v = mode == 0 || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
            if (v) begin
                for (int i = 0; i < 32; i++) w[i] = tx.size() > 0 ? tx.pop_front() : 1'($urandom);
                pma_data = w;
                sent++;
            end
            pma_valid = v;
            cyc++;
        end
        if (sent < n) chk("feed_budget", 66'(sent), 66'(n));
        @(posedge clk_ref); #1;
        pma_valid = 0;
    endtask

    task automatic pulse_reset(input bit clr);
        @(posedge clk_ref); #1;
        rst_ref = 1; pma_valid = 0;
        if (clr) begin tx.delete(); sd.delete(); end
        outq.delete();
        lock_words = 0; fall_n = -1; fall_err = -1; fall_loss = -1;
        @(posedge clk_ref); #1;
        rst_ref = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ref = 1; pma_valid = 0; pma_data = '0;
        @(posedge clk_ref); #1;
        chk_en = 1;
        @(negedge clk_ref);
        chk("rst_valid", 66'(blk_valid), 66'd0);
        chk("rst_lock", 66'(block_lock), 66'd0);
        chk("rst_data", {blk_data, blk_hdr}, 66'd0);

        // aligned lock, 15 bad headers in first window, 16 in the second
        pulse_reset(1);
        add_blocks(70, 0); add_blocks(15, 100); add_blocks(45, 0);
        add_blocks(16, 100); add_blocks(150, 0);
        feed(600, 0);
        repeat (4) @(posedge clk_ref);
        chk("lock_words", 66'(lock_words), 66'd132);
        chk("slips_aligned", 66'(slips_at_lock), 66'd0);
        chk("first_out", oq(0), sd[64]);
        chk("outs_at_fall", 66'(fall_n), 66'd82);
        chk("fall_block", fall_d, sd[145]);
`ifdef G10_RX_SYNC_STATS_EN
        chk("fall_err_cnt", 66'(fall_err), 66'd31);
        chk("fall_loss_cnt", 66'(fall_loss), 66'd1);
`endif

        // 13-bit misalignment: exactly 13 slips, then gapless payloads
        pulse_reset(1);
        add_junk(13); add_blocks(250, 0);
        feed(520, 0);
        repeat (4) @(posedge clk_ref);
        chk("slips_13", 66'(slips_at_lock), 66'd13);
        begin
            int j0 = -1;
            for (int j = 0; j < sd.size(); j++) if (j0 < 0 && sd[j] === oq(0)) j0 = j;
            chk("seq_found", 66'(j0 >= 0), 66'd1);
            for (int k = 1; k < 30; k++) chk("seq", oq(k), j0 >= 0 && j0 + k < sd.size() ? sd[j0 + k] : 'x);
        end

        // alternating pma_valid: same block sequence and word count to lock
        pulse_reset(1);
        add_blocks(150, 0);
        feed(160, 1);
        repeat (4) @(posedge clk_ref);
        chk("lock_words_tog", 66'(lock_words), 66'd132);
        chk("tog_out0", oq(0), sd[64]);
        chk("tog_out1", oq(1), sd[65]);

        // reset while locked mid-block, then a fresh aligned stream
        pulse_reset(1);
        tx.delete(); sd.delete();
        @(negedge clk_ref);
        chk("midrst_lock", 66'(block_lock), 66'd0);
        chk("midrst_valid", 66'(blk_valid), 66'd0);
        chk("midrst_data", {blk_data, blk_hdr}, 66'd0);
        add_blocks(90, 0);
        feed(150, 0);
        repeat (4) @(posedge clk_ref);
        chk("relock_words", 66'(lock_words), 66'd132);
        chk("relock_out0", oq(0), sd[64]);

        // randomized offsets, gaps, error injection and mid-stream resets
        for (int r = 0; r < 3; r++) begin
            pulse_reset(1);
            add_junk($urandom_range(0, 65));
            add_blocks(80, 0);
            add_blocks(300, 4);
            feed(350, 2);
            pulse_reset(0);
            feed(250, 2);
            repeat (4) @(posedge clk_ref);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
